// File: rtl/blackparrot_fpga_host_pkg.sv
// Shared types for the BlackParrot FPGA host AXI-Lite read arbiter.
package blackparrot_fpga_host_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_addr = 2'd1,
        e_resp = 2'd2
    } bp_fpga_host_rd_arb_state_e;

    // Owner/tag index width: a single master still needs one bit to name it.
    function automatic int owner_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin requester picker; the pointer moves past the winner only once
// the whole transaction it started has finished (advance_i).
module bsg_arb_round_robin
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int WIDTH_P = 2,
    parameter int TAG_W   = owner_width(WIDTH_P)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               grants_en_i,
    input  logic [WIDTH_P-1:0] reqs_i,
    output logic [WIDTH_P-1:0] grants_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               advance_i
);

    logic [TAG_W-1:0] ptr_r;
    logic [TAG_W-1:0] next_ptr_r;
    logic [TAG_W-1:0] tag_s;
    logic             found_s;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] t);
        if (WIDTH_P == 1) begin
            return '0;
        end else if (t == TAG_W'(WIDTH_P - 1)) begin
            return '0;
        end else begin
            return t + TAG_W'(1);
        end
    endfunction

    // Pointer register; the successor of the winner is parked until advance.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            ptr_r      <= '0;
            next_ptr_r <= '0;
        end else begin
            if (yumi_i) begin
                next_ptr_r <= wrap_inc(tag_s);
            end
            if (advance_i) begin
                ptr_r <= next_ptr_r;
            end
        end
    end

    // First requester at or after the pointer, wrapping from N-1 to 0.
    always_comb begin : pick
        int idx;
        tag_s   = '0;
        found_s = 1'b0;
        idx     = 0;
        for (int i = 0; i < WIDTH_P; i++) begin
            idx = int'(ptr_r) + i;
            if (idx >= WIDTH_P) begin
                idx = idx - WIDTH_P;
            end else begin
                idx = idx;
            end
            if (!found_s && reqs_i[idx]) begin
                found_s = 1'b1;
                tag_s   = TAG_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant, only while enabled.
    always_comb begin
        grants_o = '0;
        for (int i = 0; i < WIDTH_P; i++) begin
            grants_o[i] = grants_en_i & found_s & (tag_s == TAG_W'(i));
        end
    end

    assign tag_o = tag_s;
    assign v_o   = grants_en_i & found_s;

endmodule

// File: rtl/blackparrot_fpga_host_axil_read_arbiter.sv
// Shares one AXI-Lite read slave among NUM_MASTERS_P read masters with
// round-robin arbitration and a single outstanding read.
module blackparrot_fpga_host_axil_read_arbiter
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int NUM_MASTERS_P     = 2,
    parameter int S_AXIL_ADDR_WIDTH = 64,
    parameter int S_AXIL_DATA_WIDTH = 32
) (
    input  logic                                                s_axil_aclk,
    input  logic                                                s_axil_aresetn,
    input  logic [NUM_MASTERS_P-1:0][S_AXIL_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic [NUM_MASTERS_P-1:0]                            s_axil_arvalid,
    output logic [NUM_MASTERS_P-1:0]                            s_axil_arready,
    input  logic [NUM_MASTERS_P-1:0][2:0]                       s_axil_arprot,
    output logic [NUM_MASTERS_P-1:0][S_AXIL_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [NUM_MASTERS_P-1:0]                            s_axil_rvalid,
    input  logic [NUM_MASTERS_P-1:0]                            s_axil_rready,
    output logic [NUM_MASTERS_P-1:0][1:0]                       s_axil_rresp,
    output logic [S_AXIL_ADDR_WIDTH-1:0]                        m_axil_araddr,
    output logic                                                m_axil_arvalid,
    input  logic                                                m_axil_arready,
    output logic [2:0]                                          m_axil_arprot,
    input  logic [S_AXIL_DATA_WIDTH-1:0]                        m_axil_rdata,
    input  logic                                                m_axil_rvalid,
    output logic                                                m_axil_rready,
    input  logic [1:0]                                          m_axil_rresp
);

    localparam int OWNER_W = owner_width(NUM_MASTERS_P);

    bp_fpga_host_rd_arb_state_e state_r, state_s;
    logic [S_AXIL_ADDR_WIDTH-1:0] araddr_r;
    logic [2:0]                   arprot_r;
    logic [OWNER_W-1:0]           owner_r;

    logic [NUM_MASTERS_P-1:0] grants_s;
    logic [OWNER_W-1:0]       grant_tag_s;
    logic                     grant_v_s;
    logic                     arb_en_s;
    logic                     r_hs_s;

    assign arb_en_s = (state_r == e_idle) & s_axil_aresetn;
    assign r_hs_s   = (state_r == e_resp) & m_axil_rvalid & m_axil_rready;

    bsg_arb_round_robin #(
        .WIDTH_P (NUM_MASTERS_P),
        .TAG_W   (OWNER_W)
    ) u_arb (
        .clk_i       (s_axil_aclk),
        .reset_n_i   (s_axil_aresetn),
        .grants_en_i (arb_en_s),
        .reqs_i      (s_axil_arvalid),
        .grants_o    (grants_s),
        .tag_o       (grant_tag_s),
        .v_o         (grant_v_s),
        .yumi_i      (grant_v_s),
        .advance_i   (r_hs_s)
    );

    // State and captured request (address, prot, owner).
    always_ff @(posedge s_axil_aclk) begin
        if (!s_axil_aresetn) begin
            state_r  <= e_idle;
            araddr_r <= '0;
            arprot_r <= 3'b000;
            owner_r  <= '0;
        end else begin
            state_r <= state_s;
            if (grant_v_s) begin
                araddr_r <= s_axil_araddr[grant_tag_s];
                arprot_r <= s_axil_arprot[grant_tag_s];
                owner_r  <= grant_tag_s;
            end
        end
    end

    // Next state and handshake steering; everything quiet while in reset.
    always_comb begin
        state_s        = state_r;
        s_axil_arready = '0;
        s_axil_rvalid  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        if (s_axil_aresetn) begin
            case (state_r)
                e_idle: begin
                    s_axil_arready = grants_s & s_axil_arvalid;
                    if (grant_v_s) begin
                        state_s = e_addr;
                    end else begin
                        state_s = e_idle;
                    end
                end
                e_addr: begin
                    m_axil_arvalid = 1'b1;
                    if (m_axil_arready) begin
                        state_s = e_resp;
                    end else begin
                        state_s = e_addr;
                    end
                end
                e_resp: begin
                    s_axil_rvalid[owner_r] = m_axil_rvalid;
                    m_axil_rready          = s_axil_rready[owner_r];
                    if (m_axil_rvalid && s_axil_rready[owner_r]) begin
                        state_s = e_idle;
                    end else begin
                        state_s = e_resp;
                    end
                end
                default: begin
                    state_s = e_idle;
                end
            endcase
        end else begin
            state_s = e_idle;
        end
    end

    assign m_axil_araddr = araddr_r;
    assign m_axil_arprot = arprot_r;

    // Data and response fan out to everyone; only the owner's rvalid qualifies them.
    for (genvar g = 0; g < NUM_MASTERS_P; g++) begin : g_bcast
        assign s_axil_rdata[g] = m_axil_rdata;
        assign s_axil_rresp[g] = m_axil_rresp;
    end

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_read_arbiter.sv
// Directed bench for the two-master AXI-Lite read arbiter.
module tb_blackparrot_fpga_host_axil_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   aresetn;
    logic [N-1:0][AW-1:0]   s_araddr;
    logic [N-1:0]           s_arvalid;
    logic [N-1:0]           s_arready;
    logic [N-1:0][2:0]      s_arprot;
    logic [N-1:0][DW-1:0]   s_rdata;
    logic [N-1:0]           s_rvalid;
    logic [N-1:0]           s_rready;
    logic [N-1:0][1:0]      s_rresp;
    logic [AW-1:0]          m_araddr;
    logic                   m_arvalid;
    logic                   m_arready;
    logic [2:0]             m_arprot;
    logic [DW-1:0]          m_rdata;
    logic                   m_rvalid;
    logic                   m_rready;
    logic [1:0]             m_rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blackparrot_fpga_host_axil_read_arbiter #(
        .NUM_MASTERS_P     (N),
        .S_AXIL_ADDR_WIDTH (AW),
        .S_AXIL_DATA_WIDTH (DW)
    ) dut (
        .s_axil_aclk    (clk),
        .s_axil_aresetn (aresetn),
        .s_axil_araddr  (s_araddr),
        .s_axil_arvalid (s_arvalid),
        .s_axil_arready (s_arready),
        .s_axil_arprot  (s_arprot),
        .s_axil_rdata   (s_rdata),
        .s_axil_rvalid  (s_rvalid),
        .s_axil_rready  (s_rready),
        .s_axil_rresp   (s_rresp),
        .m_axil_araddr  (m_araddr),
        .m_axil_arvalid (m_arvalid),
        .m_axil_arready (m_arready),
        .m_axil_arprot  (m_arprot),
        .m_axil_rdata   (m_rdata),
        .m_axil_rvalid  (m_rvalid),
        .m_axil_rready  (m_rready),
        .m_axil_rresp   (m_rresp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete read with hand-computed owner and expected address/prot/data.
    task automatic run_txn(input logic [1:0] req, input int owner,
                           input logic [63:0] addr_exp, input logic [2:0] prot_exp,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int ar_stall, input int r_stall);
        logic [1:0] oh;
        oh = 2'b01 << owner;
        s_arvalid = req;
        #1;
        check("arready_grant", 64'(s_arready), 64'(oh));
        tick();
        s_arvalid = req & ~oh;
        #1;
        check("m_arvalid_t1", 64'(m_arvalid), 64'd1);
        check("m_araddr", m_araddr, addr_exp);
        check("m_arprot", 64'(m_arprot), 64'(prot_exp));
        check("arready_busy", 64'(s_arready), 64'd0);
        for (int i = 0; i < ar_stall; i++) begin
            tick();
            check("araddr_stall", m_araddr, addr_exp);
            check("arprot_stall", 64'(m_arprot), 64'(prot_exp));
            check("no_grant_stall", 64'(s_arready), 64'd0);
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = data;
        m_rresp   = resp;
        s_rready  = (r_stall > 0) ? ~oh : 2'b11;
        #1;
        for (int i = 0; i < r_stall; i++) begin
            check("m_rready_stall", 64'(m_rready), 64'd0);
            check("rvalid_stall", 64'(s_rvalid), 64'(oh));
            tick();
        end
        s_rready = 2'b11;
        #1;
        check("m_rready", 64'(m_rready), 64'd1);
        check("rvalid_owner", 64'(s_rvalid), 64'(oh));
        check("rdata_owner", 64'(s_rdata[owner]), 64'(data));
        check("rresp_owner", 64'(s_rresp[owner]), 64'(resp));
        tick();
        m_rvalid = 1'b0;
        #1;
        check("rvalid_done", 64'(s_rvalid), 64'd0);
        check("m_arvalid_done", 64'(m_arvalid), 64'd0);
    endtask

    initial begin
        aresetn   = 1'b0;
        s_araddr  = '0;
        s_arvalid = 2'b11;
        s_arprot  = '0;
        s_rready  = 2'b00;
        m_arready = 1'b0;
        m_rdata   = '0;
        m_rvalid  = 1'b0;
        m_rresp   = 2'b00;
        tick();
        tick();
        check("rst_arready", 64'(s_arready), 64'd0);
        check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_rvalid", 64'(s_rvalid), 64'd0);
        check("rst_araddr", m_araddr, 64'd0);
        aresetn   = 1'b1;
        s_arvalid = 2'b00;
        tick();
        check("idle_m_arvalid", 64'(m_arvalid), 64'd0);
        check("idle_m_rready", 64'(m_rready), 64'd0);

        // Single read from M0.
        s_araddr[0] = 64'h10;
        run_txn(2'b01, 0, 64'h10, 3'b000, 32'hDEADBEEF, 2'b00, 0, 0);

        s_araddr[0] = 64'h100;
        s_araddr[1] = 64'h200;
        s_arprot[1] = 3'b101;
        // Pointer now at 1: alternation M1, M0 with a 5-cycle AR stall on M0.
        run_txn(2'b11, 1, 64'h200, 3'b101, 32'hB1, 2'b00, 0, 0);
        run_txn(2'b11, 0, 64'h100, 3'b000, 32'hA0, 2'b00, 5, 0);
        // M1 with prot 101, SLVERR and a 4-cycle rready stall.
        run_txn(2'b11, 1, 64'h200, 3'b101, 32'hCAFE, 2'b10, 0, 4);
        run_txn(2'b01, 0, 64'h100, 3'b000, 32'h5555, 2'b00, 0, 0);

        // Pointer at 1: M1 wins, then reset lands while in e_resp.
        s_arvalid = 2'b11;
        #1;
        check("pre_rst_grant", 64'(s_arready), 64'd2);
        tick();
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h1234;
        s_rready  = 2'b11;
        #1;
        check("pre_rst_rvalid", 64'(s_rvalid), 64'd2);
        aresetn = 1'b0;
        tick();
        check("mid_rst_rvalid", 64'(s_rvalid), 64'd0);
        check("mid_rst_m_rready", 64'(m_rready), 64'd0);
        check("mid_rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("mid_rst_arready", 64'(s_arready), 64'd0);
        check("mid_rst_araddr", m_araddr, 64'd0);
        aresetn   = 1'b1;
        m_rvalid  = 1'b0;
        s_arvalid = 2'b00;
        tick();
        check("post_rst_rvalid", 64'(s_rvalid), 64'd0);
        // Pointer back at 0: M0 first.
        run_txn(2'b11, 0, 64'h100, 3'b000, 32'h77, 2'b00, 0, 0);
        s_arvalid = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
